permutation_step3: RTL and testbench

PERMUTATION_STEP3 -- requirements
Module: permutation_step3

---
 rtl/ascon_pack.sv | 29 ++
 rtl/permutation_step3_if.sv | 27 ++
 rtl/ascon_sbox.sv | 9 +
 rtl/permutation_step3.sv | 94 +++++++++
 tb/tb_permutation_step3.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/ascon_pack.sv
// ascon_pack: shared types and constants for the ASCON permutation round.
//   type_state  : five 64-bit state words x0..x4 (index 0 = x0)
//   SBOX_TABLE  : 5-bit ASCON S-box, indexed by the column value {x0,x1,x2,x3,x4}
//   round_const : 8-bit round constant XORed into the low byte of x2
//   ror64       : 64-bit rotate right
package ascon_pack;

   typedef logic [0:4][63:0] type_state;

   localparam logic [4:0] SBOX_TABLE [0:31] = '{
      5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
      5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
      5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
      5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
   };

   // High nibble counts down while the low nibble counts up; rounds 12..15
   // simply follow the same formula.
   function automatic logic [7:0] round_const(input logic [3:0] r);
      return {4'hF - r, r};
   endfunction

   function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] n);
      logic [127:0] dbl;
      dbl = {x, x} >> n;
      return dbl[63:0];
   endfunction

endpackage

// File: rtl/permutation_step3_if.sv
// permutation_step3_if: bundle of the permutation datapath signals.
//   master : drives state/data/key/controls, receives permutation_o and C_o
//   slave  : the permutation round itself
interface permutation_step3_if import ascon_pack::*;;
   type_state     permutation_i;
   logic [63:0]   data_i;
   logic [127:0]  key_i;
   logic          selectionp_i;
   logic          enable_i;
   logic          bypass_i;
   logic          mode_int_ext_i;
   logic [3:0]    round_i;
   type_state     permutation_o;
   logic [63:0]   C_o;

   modport master (
      output permutation_i, data_i, key_i, selectionp_i, enable_i,
             bypass_i, mode_int_ext_i, round_i,
      input  permutation_o, C_o
   );

   modport slave (
      input  permutation_i, data_i, key_i, selectionp_i, enable_i,
             bypass_i, mode_int_ext_i, round_i,
      output permutation_o, C_o
   );
endinterface

// File: rtl/ascon_sbox.sv
// ascon_sbox: combinational 5-bit ASCON S-box for one bit column.
//   x_i : column {x0[j],x1[j],x2[j],x3[j],x4[j]}, x0 is the MSB
//   y_o : substituted column, same bit order
module ascon_sbox import ascon_pack::*; (
   input  logic [4:0] x_i,
   output logic [4:0] y_o
);
   assign y_o = SBOX_TABLE[x_i];
endmodule

// File: rtl/permutation_step3.sv
// permutation_step3: one ASCON permutation round per enabled clock.
//   clock_i        : rising-edge clock
//   resetb_i       : asynchronous active-high reset, clears state and C_o
//   permutation_i  : external state, used when selectionp_i = 0
//   data_i         : block absorbed into x0 (bypass_i=0, mode_int_ext_i=0)
//   key_i          : key injected into x3/x4 (bypass_i=0, mode_int_ext_i=1)
//   selectionp_i   : 0 = permutation_i, 1 = internal state register
//   enable_i       : 1 = state and C_o registers may update
//   bypass_i       : 1 = skip the begin-XOR
//   mode_int_ext_i : begin-XOR source select
//   round_i        : round index selecting the constant
//   permutation_o  : state register
//   C_o            : registered x0 after the data XOR
module permutation_step3 import ascon_pack::*; (
   input  logic          clock_i,
   input  logic          resetb_i,
   input  type_state     permutation_i,
   input  logic [63:0]   data_i,
   input  logic [127:0]  key_i,
   input  logic          selectionp_i,
   input  logic          enable_i,
   input  logic          bypass_i,
   input  logic          mode_int_ext_i,
   input  logic [3:0]    round_i,
   output type_state     permutation_o,
   output logic [63:0]   C_o
);

   type_state   state_q, state_d;
   logic [63:0] c_q, c_d;
   type_state   mux_s, bx_s, ca_s, sb_s;
   logic [4:0]  col_in  [0:63];
   logic [4:0]  col_out [0:63];

   // input mux -> begin-XOR -> constant addition -> column slicing
   always_comb begin
      mux_s = selectionp_i ? state_q : permutation_i;
      bx_s  = mux_s;
      if (!bypass_i) begin
         if (!mode_int_ext_i) begin
            bx_s[0] = mux_s[0] ^ data_i;
         end else begin
            bx_s[3] = mux_s[3] ^ key_i[127:64];
            bx_s[4] = mux_s[4] ^ key_i[63:0];
         end
      end
      ca_s = bx_s;
      ca_s[2][7:0] = bx_s[2][7:0] ^ round_const(round_i);
      for (int j = 0; j < 64; j++) begin
         col_in[j] = {ca_s[0][j], ca_s[1][j], ca_s[2][j], ca_s[3][j], ca_s[4][j]};
      end
   end

   for (genvar j = 0; j < 64; j++) begin : g_sbox
      ascon_sbox u_sbox (.x_i(col_in[j]), .y_o(col_out[j]));
   end

   // reassemble words from columns, linear diffusion, next-state select
   always_comb begin
      sb_s = '0;
      for (int j = 0; j < 64; j++) begin
         sb_s[0][j] = col_out[j][4];
         sb_s[1][j] = col_out[j][3];
         sb_s[2][j] = col_out[j][2];
         sb_s[3][j] = col_out[j][1];
         sb_s[4][j] = col_out[j][0];
      end
      state_d = state_q;
      c_d     = c_q;
      if (enable_i) begin
         state_d[0] = sb_s[0] ^ ror64(sb_s[0], 6'd19) ^ ror64(sb_s[0], 6'd28);
         state_d[1] = sb_s[1] ^ ror64(sb_s[1], 6'd61) ^ ror64(sb_s[1], 6'd39);
         state_d[2] = sb_s[2] ^ ror64(sb_s[2], 6'd1)  ^ ror64(sb_s[2], 6'd6);
         state_d[3] = sb_s[3] ^ ror64(sb_s[3], 6'd10) ^ ror64(sb_s[3], 6'd17);
         state_d[4] = sb_s[4] ^ ror64(sb_s[4], 6'd7)  ^ ror64(sb_s[4], 6'd41);
         // C_o captures the ciphertext word only on a data-absorb cycle
         if (!bypass_i && !mode_int_ext_i) c_d = bx_s[0];
      end
   end

   always_ff @(posedge clock_i or posedge resetb_i) begin
      if (resetb_i) begin
         state_q <= '0;
         c_q     <= '0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
      end
   end

   assign permutation_o = state_q;
   assign C_o           = c_q;

endmodule

// File: tb/tb_permutation_step3.sv
// tb_permutation_step3: randomized and directed checks of permutation_step3
// against a bit-sliced software-style ASCON round model.
module tb_permutation_step3;
   import ascon_pack::*;

   logic clk;
   logic rst;
   permutation_step3_if bus ();

   permutation_step3 dut (
      .clock_i        (clk),
      .resetb_i       (rst),
      .permutation_i  (bus.permutation_i),
      .data_i         (bus.data_i),
      .key_i          (bus.key_i),
      .selectionp_i   (bus.selectionp_i),
      .enable_i       (bus.enable_i),
      .bypass_i       (bus.bypass_i),
      .mode_int_ext_i (bus.mode_int_ext_i),
      .round_i        (bus.round_i),
      .permutation_o  (bus.permutation_o),
      .C_o            (bus.C_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;

   type_state   m_st;
   logic [63:0] m_c;

   localparam logic [127:0] KEY = 128'h000102030405060708090A0B0C0D0E0F;

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // Reference round written like the ASCON C implementation (bit-sliced S-box).
   function automatic type_state model_round(input type_state s, input logic [63:0] d,
                                             input logic [127:0] k, input logic byp,
                                             input logic mode, input logic [3:0] r);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      type_state o;
      x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
      if (!byp) begin
         if (!mode) x0 = x0 ^ d;
         else begin x3 = x3 ^ k[127:64]; x4 = x4 ^ k[63:0]; end
      end
      x2 = x2 ^ 64'((15 - int'(r)) * 16 + int'(r));
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      o[0] = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
      o[1] = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
      o[2] = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
      o[3] = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
      o[4] = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
      return o;
   endfunction

   // Drive one clock of stimulus, advance the model, return at posedge+1.
   task automatic drive_cycle(input logic sel, input logic byp, input logic mode,
                              input logic en, input logic [3:0] r, input logic [63:0] d,
                              input logic [127:0] k, input type_state p);
      type_state src;
      bus.selectionp_i = sel; bus.bypass_i = byp; bus.mode_int_ext_i = mode;
      bus.enable_i = en; bus.round_i = r; bus.data_i = d; bus.key_i = k;
      bus.permutation_i = p;
      src = sel ? m_st : p;
      if (en) begin
         if (!byp && !mode) m_c = src[0] ^ d;
         m_st = model_round(src, d, k, byp, mode, r);
      end
      @(posedge clk);
      #1;
   endtask

   function automatic type_state rand_state();
      type_state s;
      for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
      return s;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      bus.permutation_i = rand_state(); bus.data_i = '1; bus.key_i = '1;
      bus.selectionp_i = 1'b0; bus.enable_i = 1'b1; bus.bypass_i = 1'b0;
      bus.mode_int_ext_i = 1'b0; bus.round_i = 4'd6;
      #2;
      n_tot++;
      if (bus.permutation_o !== '0) $display("FAIL reset_state got %h exp 0", bus.permutation_o);
      else n_pass++;
      n_tot++;
      if (bus.C_o !== 64'd0) $display("FAIL reset_c got %h exp 0", bus.C_o);
      else n_pass++;
      // reset must dominate an enabled clock edge
      @(posedge clk); #1;
      n_tot++;
      if (bus.permutation_o !== '0 || bus.C_o !== 64'd0)
         $display("FAIL reset_edge got %h / %h exp 0", bus.permutation_o, bus.C_o);
      else n_pass++;
      #2 rst = 1'b0;
      m_st = '0; m_c = '0;
   endtask

   task automatic test_first_round();
      type_state p;
      p = '{64'h4608da0e76fcee25, 64'h876f2d998dd3ed21, 64'h5d5b8b59b7ac16ee,
            64'he23c656f97f63dc8, 64'h3e09499302483746};
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 64'h436F6E636576657A, '0, p);
      n_tot++;
      if (bus.C_o !== 64'h0567B46D138A8B5F)
         $display("FAIL first_c got %h exp 0567b46d138a8b5f", bus.C_o);
      else n_pass++;
      n_tot++;
      if (bus.permutation_o !== m_st)
         $display("FAIL first_state got %h exp %h", bus.permutation_o, m_st);
      else n_pass++;
   endtask

   task automatic test_p6_rounds();
      for (int r = 7; r <= 11; r++) begin
         drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'(r), {$urandom, $urandom}, '1, rand_state());
         n_tot++;
         if (bus.permutation_o !== m_st || bus.C_o !== m_c)
            $display("FAIL p6_r%0d got %h c %h exp %h c %h", r, bus.permutation_o, bus.C_o, m_st, m_c);
         else n_pass++;
      end
   endtask

   task automatic test_blocks();
      logic [63:0] blk [0:1];
      blk[0] = 64'h204153434F4E2065;
      blk[1] = 64'h6E2053797374656D;
      for (int b = 0; b < 2; b++) begin
         drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'd6, blk[b], '0, rand_state());
         n_tot++;
         if (bus.C_o !== m_c) $display("FAIL block%0d_c got %h exp %h", b, bus.C_o, m_c);
         else n_pass++;
         for (int r = 7; r <= 11; r++)
            drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'(r), '0, '0, rand_state());
         n_tot++;
         if (bus.permutation_o !== m_st || bus.C_o !== m_c)
            $display("FAIL block%0d_state got %h exp %h", b, bus.permutation_o, m_st);
         else n_pass++;
      end
   endtask

   task automatic test_hold();
      type_state st0;
      logic [63:0] c0;
      st0 = m_st; c0 = m_c;
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 4'($urandom),
                     {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, rand_state());
         n_tot++;
         if (bus.permutation_o !== st0 || bus.C_o !== c0)
            $display("FAIL hold_%0d got %h c %h exp %h c %h", i, bus.permutation_o, bus.C_o, st0, c0);
         else n_pass++;
      end
   endtask

   task automatic test_key();
      logic [63:0] c0;
      c0 = m_c;
      drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'd11, {$urandom, $urandom}, KEY, rand_state());
      n_tot++;
      if (bus.permutation_o !== m_st) $display("FAIL key_state got %h exp %h", bus.permutation_o, m_st);
      else n_pass++;
      n_tot++;
      if (bus.C_o !== c0) $display("FAIL key_c got %h exp %h", bus.C_o, c0);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         drive_cycle(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                     4'($urandom), {$urandom, $urandom},
                     {$urandom, $urandom, $urandom, $urandom}, rand_state());
         n_tot++;
         if (bus.permutation_o !== m_st || bus.C_o !== m_c)
            $display("FAIL rand_%0d got %h c %h exp %h c %h", i, bus.permutation_o, bus.C_o, m_st, m_c);
         else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'd7, '0, '0, rand_state());
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'd8, '0, '0, rand_state());
      #2 rst = 1'b1;
      #1;
      n_tot++;
      if (bus.permutation_o !== '0 || bus.C_o !== 64'd0)
         $display("FAIL async_reset got %h c %h exp 0", bus.permutation_o, bus.C_o);
      else n_pass++;
      #2 rst = 1'b0;
      m_st = '0; m_c = '0;
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'd6, {$urandom, $urandom}, '0, rand_state());
      n_tot++;
      if (bus.permutation_o !== m_st || bus.C_o !== m_c)
         $display("FAIL post_reset got %h c %h exp %h c %h", bus.permutation_o, bus.C_o, m_st, m_c);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_first_round();
      test_p6_rounds();
      test_blocks();
      test_hold();
      test_key();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
